delay_chan_arbiter: RTL and testbench

- Clocked round-robin arbiter that shares one matched-delay channel (a chain of delay1U/delay2U units) between N requesters.
- Each requester uses a four-phase req/ack handshake.
- The channel is driven with a two-phase (toggle) request and returns a two-phase done; the arbiter synchronises the returned done to clk.
- Sits between cache-control requesters and the shared delay element. It also flags channels whose done never returns.

---
 rtl/delay_arb_pkg.sv | 51 +++++
 rtl/sync2.sv | 31 +++
 rtl/delay_chan_arbiter.sv | 156 +++++++++++++++
 tb/tb_delay_chan_arbiter.sv | 288 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/delay_arb_pkg.sv
// Shared types and helpers for the delay-channel arbiter.
//
// Contents:
//   arbState_t        - arbiter FSM state (IDLE, WAIT, ACK), 2 bits
//   DEFAULT_TO_CYCLES - default WAIT timeout in clk cycles
//   DEFAULT_TO_W      - default timeout counter width
//   MAX_N / RR_IDX_W  - widest requester vector the pick helper handles
//   rrPick_t, rrPick  - round-robin pick: first set request at or after a
//                       pointer, wrapping modulo n
package delay_arb_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    ACK  = 2'd2
  } arbState_t;

  localparam int DEFAULT_TO_CYCLES = 200;
  localparam int DEFAULT_TO_W      = 8;

  localparam int MAX_N    = 16;
  localparam int RR_IDX_W = 4;
  localparam int RR_POS_W = RR_IDX_W + 1;

  typedef struct packed {
    logic                valid;
    logic [RR_IDX_W-1:0] idx;
  } rrPick_t;

  // Scans offsets 0..n-1 from ptr. Because ptr < n and the offset < n, the
  // raw position is below 2n, so one conditional subtract is a full modulo.
  function automatic rrPick_t rrPick(input logic [MAX_N-1:0]    reqVec,
                                     input logic [RR_IDX_W-1:0] ptr,
                                     input int                  n);
    rrPick_t             res;
    logic [RR_POS_W-1:0] pos;
    res = '0;
    for (int i = 0; i < MAX_N; i++) begin
      pos = {1'b0, ptr} + RR_POS_W'(i);
      if (pos >= RR_POS_W'(n)) begin
        pos = pos - RR_POS_W'(n);
      end
      if ((i < n) && !res.valid && reqVec[pos[RR_IDX_W-1:0]]) begin
        res.valid = 1'b1;
        res.idx   = pos[RR_IDX_W-1:0];
      end
    end
    return res;
  endfunction

endpackage

// File: rtl/sync2.sv
// Two-flop synchroniser for bringing an asynchronous level into the clk
// domain. Both flops clear to 0 on reset so that a reset delay chain and the
// synchronised copy agree on phase 0.
//
// Ports:
//   clk  - destination clock, rising edge
//   rstn - asynchronous active-low reset
//   d    - asynchronous input (W bits, each bit treated independently)
//   q    - synchronised output, two clk edges behind d
module sync2 #(
  parameter int W = 1
) (
  input  logic         clk,
  input  logic         rstn,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  logic [W-1:0] meta;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      meta <= '0;
      q    <= '0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/delay_chan_arbiter.sv
// Round-robin arbiter sharing one matched-delay channel among N requesters.
//
// Requester side, four-phase handshake: a requester raises req[i] and holds
// it; when its transaction through the delay channel has completed the
// arbiter raises ack[i] (registered, at most one bit high); the requester
// then drops req[i], and the arbiter drops ack[i] on the following edge and
// returns to IDLE. Dropping req[i] before ack is a protocol violation; the
// transaction still finishes and ack[i] shows as a single-cycle pulse.
//
// Channel side, two-phase handshake: every grant toggles dly_req; the chain
// returns that level on dly_done after its matched delay. dly_done is
// synchronised, and the transaction is complete when the synchronised level
// equals dly_req (phase match, no edge detection).
//
// Ports:
//   clk         - system clock, rising edge
//   rstn        - asynchronous active-low reset (also resets the chain)
//   req         - four-phase request levels, one per requester
//   ack         - four-phase acknowledges, one-hot or zero
//   grant_id    - index of the current/last granted requester
//   busy        - high whenever the FSM is not in IDLE
//   dly_req     - two-phase request into the delay chain
//   dly_done    - two-phase done from the delay chain, asynchronous to clk
//   timeout_err - one-cycle pulse when a WAIT has lasted TO_CYCLES cycles
//   dbgState    - current FSM state for observation
//
// TO_W must be wide enough to hold TO_CYCLES, and N must not exceed MAX_N.
module delay_chan_arbiter
  import delay_arb_pkg::*;
#(
  parameter int N         = 4,
  parameter int ID_W      = $clog2(N),
  parameter int TO_CYCLES = DEFAULT_TO_CYCLES,
  parameter int TO_W      = DEFAULT_TO_W
) (
  input  logic            clk,
  input  logic            rstn,
  input  logic [N-1:0]    req,
  output logic [N-1:0]    ack,
  output logic [ID_W-1:0] grant_id,
  output logic            busy,
  output logic            dly_req,
  input  logic            dly_done,
  output logic            timeout_err,
  output logic [1:0]      dbgState
);

  arbState_t       state;
  arbState_t       stateNext;
  logic [N-1:0]    ackNext;
  logic [ID_W-1:0] grantNext;
  logic [ID_W-1:0] rrPtr;
  logic [ID_W-1:0] rrPtrNext;
  logic [ID_W-1:0] grantPlusOne;
  logic            dlyReqNext;
  logic [TO_W-1:0] waitCnt;
  logic [TO_W-1:0] waitCntNext;
  logic            toErrNext;
  logic            toFired;
  logic            toFiredNext;
  logic            doneS;
  logic            phaseMatch;
  rrPick_t         pick;

  sync2 #(.W(1)) uDoneSync (
    .clk  (clk),
    .rstn (rstn),
    .d    (dly_done),
    .q    (doneS)
  );

  assign phaseMatch   = (doneS == dly_req);
  assign pick         = rrPick(MAX_N'(req), RR_IDX_W'(rrPtr), N);
  assign grantPlusOne = (grant_id == ID_W'(N - 1)) ? '0 : grant_id + ID_W'(1);
  assign busy         = (state != IDLE);
  assign dbgState     = state;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state       <= IDLE;
      ack         <= '0;
      grant_id    <= '0;
      rrPtr       <= '0;
      dly_req     <= 1'b0;
      waitCnt     <= '0;
      timeout_err <= 1'b0;
      toFired     <= 1'b0;
    end else begin
      state       <= stateNext;
      ack         <= ackNext;
      grant_id    <= grantNext;
      rrPtr       <= rrPtrNext;
      dly_req     <= dlyReqNext;
      waitCnt     <= waitCntNext;
      timeout_err <= toErrNext;
      toFired     <= toFiredNext;
    end
  end

  always_comb begin
    stateNext   = state;
    ackNext     = ack;
    grantNext   = grant_id;
    rrPtrNext   = rrPtr;
    dlyReqNext  = dly_req;
    waitCntNext = waitCnt;
    toErrNext   = 1'b0;
    toFiredNext = toFired;

    unique case (state)
      IDLE: begin
        if (pick.valid) begin
          grantNext   = pick.idx[ID_W-1:0];
          dlyReqNext  = ~dly_req;
          waitCntNext = '0;
          toFiredNext = 1'b0;
          stateNext   = WAIT;
        end
      end

      WAIT: begin
        if (phaseMatch) begin
          ackNext           = '0;
          ackNext[grant_id] = 1'b1;
          stateNext         = ACK;
        end else begin
          if (waitCnt != '1) begin
            waitCntNext = waitCnt + TO_W'(1);
          end
          // The counter equals k-1 on the k-th WAIT edge, so this fires on
          // the TO_CYCLES-th edge after the grant. toFired keeps it to one
          // pulse per transaction even if the counter sits saturated on the
          // compare value. The FSM deliberately stays in WAIT: leaving would
          // strand the chain in the opposite phase.
          if (!toFired && (waitCnt == TO_W'(TO_CYCLES - 1))) begin
            toErrNext   = 1'b1;
            toFiredNext = 1'b1;
          end
        end
      end

      ACK: begin
        if (!req[grant_id]) begin
          ackNext   = '0;
          rrPtrNext = grantPlusOne;
          stateNext = IDLE;
        end
      end

      default: begin
        stateNext = IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_delay_chan_arbiter.sv
module tb_delay_chan_arbiter;

  localparam int N      = 4;
  localparam int TO_CYC = 200;
  localparam int W      = 16;

  // ---------------- clock / reset / DUT ----------------
  logic         clk      = 1'b0;
  logic         rstn     = 1'b0;
  logic [N-1:0] req      = '0;
  logic [N-1:0] ack;
  logic [1:0]   grant_id;
  logic         busy;
  logic         dly_req;
  logic         dly_done;
  logic         timeout_err;
  logic [1:0]   dbgState;

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  delay_chan_arbiter #(
    .N         (N),
    .ID_W      (2),
    .TO_CYCLES (TO_CYC),
    .TO_W      (8)
  ) dut (
    .clk         (clk),
    .rstn        (rstn),
    .req         (req),
    .ack         (ack),
    .grant_id    (grant_id),
    .busy        (busy),
    .dly_req     (dly_req),
    .dly_done    (dly_done),
    .timeout_err (timeout_err),
    .dbgState    (dbgState)
  );

  // Delay chain model: chainD clk cycles of delay, reset to 0 with rstn.
  logic [4:0]  chainD   = 5'd0;
  logic        stuckLow = 1'b0;
  logic [31:0] hist;

  always @(posedge clk or negedge rstn) begin
    if (!rstn) hist <= '0;
    else       hist <= {hist[30:0], dly_req};
  end

  always_comb begin
    dly_done = 1'b0;
    if (stuckLow)          dly_done = 1'b0;
    else if (chainD == 0)  dly_done = dly_req;
    else                   dly_done = hist[chainD - 5'd1];
  end

  // ---------------- scoreboard state ----------------
  int checks   = 0;
  int failures = 0;
  // entry: [15] expected dly_req phase, [14:4] grant-to-ack edges, [3:0] id
  logic [W-1:0] exp_q[$];
  int   mPtr      = 0;
  logic mPhase    = 1'b0;
  int   toCount   = 0;
  int   toCyc     = -1;
  int   grantCyc  = -1;
  int   lastAckId = -1;
  logic [N-1:0] prevAck    = '0;
  logic         prevDlyReq = 1'b0;

  task automatic checkEq(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic bit bitAt(input logic [N-1:0] v, input int i);
    logic [N-1:0] s;
    s = v >> i;
    return s[0];
  endfunction

  // Reference arbitration: first requester at or after the pointer, wrapping.
  function automatic int modelPick(input logic [N-1:0] r, input int ptr);
    for (int i = 0; i < N; i++) begin
      if (bitAt(r, (ptr + i) % N)) return (ptr + i) % N;
    end
    return -1;
  endfunction

  // ---------------- monitor ----------------
  always @(negedge clk) begin
    logic [W-1:0] e;
    if (rstn) begin
      if (dly_req !== prevDlyReq) grantCyc = cyc;
      if (timeout_err === 1'b1) begin
        toCount++;
        toCyc = cyc;
      end
      if (ack !== prevAck) checkEq("ack_onehot0", int'($countones(ack) <= 1), 1);
      if (prevAck == '0 && ack != '0) begin
        lastAckId = int'(grant_id);
        if (exp_q.size() == 0) begin
          checkEq("unexpected_ack", int'(ack), 0);
        end else begin
          e = exp_q.pop_front();
          checkEq("ack_vector", int'(ack), 1 << e[3:0]);
          checkEq("ack_grant_id", int'(grant_id), int'(e[3:0]));
          checkEq("ack_latency", cyc - grantCyc, int'(e[14:4]));
          checkEq("ack_phase", int'(dly_req), int'(e[15]));
        end
      end
    end
    prevAck    = ack;
    prevDlyReq = dly_req;
  end

  // ---------------- driver tasks ----------------
  task automatic issue(input logic [N-1:0] r, input bit pushNow, output int w);
    req    = r;
    w      = modelPick(r, mPtr);
    mPhase = ~mPhase;
    if (pushNow) exp_q.push_back({mPhase, 11'(3 + int'(chainD)), 4'(w)});
    mPtr = (w + 1) % N;
  endtask

  task automatic waitAck(input int w, input int limit);
    int k = 0;
    while (!bitAt(ack, w) && k < limit) begin
      @(negedge clk);
      k++;
    end
    if (!bitAt(ack, w)) checkEq("ack_wait_expired", int'(ack), 1 << w);
  endtask

  task automatic runTxn(input logic [N-1:0] r, output int w);
    issue(r, 1'b1, w);
    @(negedge clk);
    waitAck(w, 40);
    req = req & ~(N'(1) << w);
    @(negedge clk);
    checkEq("ack_released", int'(ack), 0);
    checkEq("busy_after_release", int'(busy), 0);
    req = '0;
  endtask

  task automatic setChain(input int d);
    req = '0;
    repeat (40) @(negedge clk);
    chainD = 5'(d);
  endtask

  task automatic doReset();
    @(negedge clk);
    #2;
    rstn = 1'b0;
    req  = '0;
    #1;
    checkEq("rst_ack", int'(ack), 0);
    checkEq("rst_grant_id", int'(grant_id), 0);
    checkEq("rst_busy", int'(busy), 0);
    checkEq("rst_dly_req", int'(dly_req), 0);
    checkEq("rst_timeout_err", int'(timeout_err), 0);
    exp_q.delete();
    mPtr   = 0;
    mPhase = 1'b0;
    repeat (3) @(negedge clk);
    rstn = 1'b1;
    repeat (2) @(negedge clk);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int w;
    int gExp;
    int rel;
    int toBase;
    logic [N-1:0] r;
    int expOrder[5];
    expOrder = '{0, 1, 2, 3, 0};

    doReset();

    // Single requester, chain tied through: grant 1 edge, ack 4 edges later.
    issue(4'b0100, 1'b1, w);
    @(negedge clk);
    checkEq("t1_dly_req", int'(dly_req), 1);
    checkEq("t1_grant_id", int'(grant_id), 2);
    checkEq("t1_busy", int'(busy), 1);
    @(negedge clk);
    @(negedge clk);
    checkEq("t1_ack_not_early", int'(ack), 0);
    @(negedge clk);
    checkEq("t1_ack_edge4", int'(ack), 4);
    req = '0;
    @(negedge clk);
    checkEq("t1_ack_drop", int'(ack), 0);
    checkEq("t1_busy_drop", int'(busy), 0);
    // Pointer now 3: of {0,3}, requester 3 must win.
    runTxn(4'b1001, w);
    checkEq("t1_ptr3_winner", lastAckId, 3);

    // All four requesting: grant order 0,1,2,3,0.
    doReset();
    for (int i = 0; i < 5; i++) begin
      runTxn(4'b1111, w);
      checkEq("rr_order", lastAckId, expOrder[i]);
    end

    // Five-cycle chain: phase 0->1 then 1->0, each ack 8 edges after grant.
    doReset();
    setChain(5);
    runTxn(4'b0010, w);
    runTxn(4'b0100, w);

    // Reset in the middle of WAIT.
    issue(4'b0100, 1'b1, w);
    repeat (3) @(negedge clk);
    checkEq("midrst_busy_before", int'(busy), 1);
    checkEq("midrst_ack_before", int'(ack), 0);
    doReset();
    runTxn(4'b0010, w);
    checkEq("midrst_after_winner", lastAckId, 1);

    // Timeout with dly_done stuck at 0.
    setChain(0);
    doReset();
    stuckLow = 1'b1;
    toBase   = toCount;
    gExp     = cyc + 1;
    issue(4'b0001, 1'b0, w);
    while (cyc < gExp + 205) @(negedge clk);
    checkEq("to_grant_cycle", grantCyc, gExp);
    checkEq("to_pulse_count", toCount - toBase, 1);
    checkEq("to_pulse_cycle", toCyc - gExp, TO_CYC);
    while (cyc < gExp + 300) @(negedge clk);
    checkEq("to_no_second_pulse", toCount - toBase, 1);
    checkEq("to_still_busy", int'(busy), 1);
    checkEq("to_no_ack", int'(ack), 0);
    stuckLow = 1'b0;
    rel = cyc;
    exp_q.push_back({1'b1, 11'(rel + 3 - gExp), 4'd0});
    waitAck(0, 10);
    req = '0;
    @(negedge clk);
    checkEq("to_ack_released", int'(ack), 0);
    checkEq("to_final_pulse_count", toCount - toBase, 1);

    // req[3] dropped during WAIT: one-cycle ack pulse, then pointer at 0.
    setChain(5);
    issue(4'b1000, 1'b1, w);
    repeat (2) @(negedge clk);
    req = '0;
    waitAck(3, 20);
    @(negedge clk);
    checkEq("viol_ack_pulse", int'(ack), 0);
    checkEq("viol_idle", int'(busy), 0);
    r = 4'($urandom_range(1, 15));
    runTxn(r, w);

    // Randomised traffic with several chain delays.
    for (int k = 0; k < 3; k++) begin
      setChain($urandom_range(0, 7));
      for (int j = 0; j < 8; j++) begin
        r = 4'($urandom_range(1, 15));
        runTxn(r, w);
      end
    end

    repeat (5) @(negedge clk);
    checkEq("queue_drained", exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #1000000;
    failures++;
    $display("FAIL watchdog: simulation did not complete (cycle %0d)", cyc);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
